// File: rtl/cnn_pkg.sv
// cnn_pkg: shared classifier constants, score limits, class-index and FSM state types
package cnn_pkg;
  localparam int FC_OUT_NUM = 10;
  localparam int FC_DATA_BITS = 12;
  localparam int FC_IDX_BITS = 4;
  localparam logic signed [FC_DATA_BITS-1:0] SCORE_MIN = {1'b1, {(FC_DATA_BITS-1){1'b0}}};
  typedef logic [FC_IDX_BITS-1:0] class_idx_t;
  typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/fc_argmax_classifier_if.sv
// fc_argmax_classifier_if: score stream in (clear, valid_in, data_in); decision bus out (decision, max_score, second_score, margin, valid_out, busy, frame_count)
interface fc_argmax_classifier_if
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = FC_DATA_BITS,
  parameter int IDX_BITS = FC_IDX_BITS,
  parameter int FRAME_CNT_BITS = 8
);
  logic clear;
  logic valid_in;
  logic signed [DATA_BITS-1:0] data_in;
  logic [IDX_BITS-1:0] decision;
  logic signed [DATA_BITS-1:0] max_score;
  logic signed [DATA_BITS-1:0] second_score;
  logic [DATA_BITS:0] margin;
  logic valid_out;
  logic busy;
  logic [FRAME_CNT_BITS-1:0] frame_count;
  modport master (output clear, valid_in, data_in,
                  input decision, max_score, second_score, margin, valid_out, busy, frame_count);
  modport slave (input clear, valid_in, data_in,
                 output decision, max_score, second_score, margin, valid_out, busy, frame_count);
endinterface

// File: rtl/fc_argmax_classifier_top2.sv
// top2_tracker: folds one score into running (max, second, max index); ports first/data/cur_idx and running values in, updated values out
module top2_tracker
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = FC_DATA_BITS,
  parameter int IDX_BITS = FC_IDX_BITS
) (
  input  logic first,
  input  logic signed [DATA_BITS-1:0] data,
  input  logic [IDX_BITS-1:0] cur_idx,
  input  logic signed [DATA_BITS-1:0] max_in,
  input  logic signed [DATA_BITS-1:0] sec_in,
  input  logic [IDX_BITS-1:0] idx_in,
  output logic signed [DATA_BITS-1:0] max_out,
  output logic signed [DATA_BITS-1:0] sec_out,
  output logic [IDX_BITS-1:0] idx_out
);
  localparam logic signed [DATA_BITS-1:0] MIN = {1'b1, {(DATA_BITS-1){1'b0}}};
  logic gt, gt_sec;
  // strict compare keeps the lowest index on ties; a tie still lifts the runner-up
  assign gt = data > max_in;
  assign gt_sec = data > sec_in;
  assign max_out = first || gt ? data : max_in;
  assign sec_out = first ? MIN : gt ? max_in : gt_sec ? data : sec_in;
  assign idx_out = first ? '0 : gt ? cur_idx : idx_in;
endmodule

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: per-frame argmax of CLASS_NUM signed scores; clk, rst (async high), bus = score stream in / registered decision out
module fc_argmax_classifier
  import cnn_pkg::*;
#(
  parameter int CLASS_NUM = FC_OUT_NUM,
  parameter int DATA_BITS = FC_DATA_BITS,
  parameter int IDX_BITS = FC_IDX_BITS,
  parameter int FRAME_CNT_BITS = 8
) (
  input logic clk,
  input logic rst,
  fc_argmax_classifier_if.slave bus
);
  localparam logic signed [DATA_BITS-1:0] MIN = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(CLASS_NUM - 1);
  state_t state, state_nx;
  logic [IDX_BITS-1:0] idx, idx_nx, run_idx, t_idx;
  logic signed [DATA_BITS-1:0] run_max, run_sec, t_max, t_sec;
  logic take, last;
  always_comb begin
    take = bus.valid_in && !bus.clear;
    last = take && idx == LAST;
    idx_nx = bus.clear || last ? '0 : take ? idx + 1'b1 : idx;
    state_nx = idx_nx != '0 ? COLLECT : IDLE;
  end
  top2_tracker #(.DATA_BITS(DATA_BITS), .IDX_BITS(IDX_BITS)) u_trk (
    .first(idx == '0), .data(bus.data_in), .cur_idx(idx),
    .max_in(run_max), .sec_in(run_sec), .idx_in(run_idx),
    .max_out(t_max), .sec_out(t_sec), .idx_out(t_idx)
  );
  assign bus.busy = state == COLLECT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      run_max <= MIN;
      run_sec <= MIN;
      run_idx <= '0;
      bus.decision <= '0;
      bus.max_score <= '0;
      bus.second_score <= '0;
      bus.margin <= '0;
      bus.valid_out <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      bus.valid_out <= last;
      if (bus.clear) begin
        run_max <= MIN;
        run_sec <= MIN;
        run_idx <= '0;
      end else if (take) begin
        run_max <= t_max;
        run_sec <= t_sec;
        run_idx <= t_idx;
      end
      if (last) begin
        bus.decision <= t_idx;
        bus.max_score <= t_max;
        bus.second_score <= t_sec;
        // one extra bit: max - second spans up to 2^DATA_BITS - 1
        bus.margin <= {t_max[DATA_BITS-1], t_max} - {t_sec[DATA_BITS-1], t_sec};
        bus.frame_count <= bus.frame_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb_fc_argmax_classifier: directed and model-checked frames for fc_argmax_classifier
module tb_fc_argmax_classifier;
  import cnn_pkg::*;
  typedef int vec_t[10];
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0, pulses = 0, tot = 0, exp_fc = 0, cyc = 0, c1 = 0;
  int e_dec = 0, e_max = 0, e_sec = 0;
  vec_t rv;
  always #5 clk = ~clk;
  fc_argmax_classifier_if #(.DATA_BITS(12), .IDX_BITS(4), .FRAME_CNT_BITS(8)) bus ();
  fc_argmax_classifier #(.CLASS_NUM(10), .DATA_BITS(12), .IDX_BITS(4), .FRAME_CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always @(negedge clk) if (bus.valid_out === 1'b1) pulses++;
  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic score(input int s);
    bus.valid_in = 1'b1;
    bus.data_in = 12'(s);
    step();
  endtask
  task automatic frame(input vec_t v, input bit gap);
    for (int i = 0; i < 10; i++) begin
      if (gap) while ($urandom_range(3) != 0) begin
        bus.valid_in = 1'b0;
        step();
      end
      if (i == 9) chk("pre_vo", longint'(bus.valid_out), 0);
      score(v[i]);
    end
  endtask
  task automatic expect_out(input string tag, input int dec, input int mx, input int sc);
    exp_fc = (exp_fc + 1) % 256;
    tot++;
    chk({tag, ".vo"}, longint'(bus.valid_out), 1);
    chk({tag, ".dec"}, longint'(bus.decision), dec);
    chk({tag, ".max"}, longint'(bus.max_score), mx);
    chk({tag, ".sec"}, longint'(bus.second_score), sc);
    chk({tag, ".margin"}, longint'(bus.margin), mx - sc);
    chk({tag, ".fc"}, longint'(bus.frame_count), exp_fc);
    chk({tag, ".busy"}, longint'(bus.busy), 0);
  endtask
  function automatic void model(input vec_t v, output int d, output int m, output int s);
    d = 0;
    for (int i = 1; i < 10; i++) if (v[i] > v[d]) d = i;
    m = v[d];
    s = -2048;
    for (int i = 0; i < 10; i++) if (i != d && v[i] > s) s = v[i];
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, ".dec"}, longint'(bus.decision), 0);
    chk({tag, ".max"}, longint'(bus.max_score), 0);
    chk({tag, ".sec"}, longint'(bus.second_score), 0);
    chk({tag, ".margin"}, longint'(bus.margin), 0);
    chk({tag, ".vo"}, longint'(bus.valid_out), 0);
    chk({tag, ".busy"}, longint'(bus.busy), 0);
    chk({tag, ".fc"}, longint'(bus.frame_count), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    step();
    step();
    rst = 1'b0;
    check_zero("reset");
    frame('{5, -3, 100, 7, 100, 0, -50, 2, 99, 1}, 1'b0);
    expect_out("tie", 2, 100, 100);
    bus.valid_in = 1'b0;
    step();
    chk("pulse_len", longint'(bus.valid_out), 0);
    chk("hold_dec", longint'(bus.decision), 2);
    frame('{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048}, 1'b0);
    expect_out("allmin", 0, -2048, -2048);
    frame('{-1, -1, -1, -1, -1, -1, -1, -1, -1, 2047}, 1'b0);
    expect_out("wide", 9, 2047, -1);
    c1 = cyc;
    frame('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 1'b0);
    expect_out("b2b_a", 9, 10, 9);
    c1 = cyc;
    frame('{-7, 40, -7, 39, 40, 0, 0, 0, 0, 0}, 1'b0);
    expect_out("b2b_b", 1, 40, 40);
    chk("b2b_gap", cyc - c1, 10);
    bus.valid_in = 1'b0;
    step();
    chk("b2b_pulses", pulses, tot);
    for (int i = 0; i < 4; i++) score(500 + i);
    chk("busy_mid", longint'(bus.busy), 1);
    bus.clear = 1'b1;
    score(77);
    bus.clear = 1'b0;
    chk("clr_busy", longint'(bus.busy), 0);
    chk("clr_fc", longint'(bus.frame_count), exp_fc);
    frame('{3, 9, 1, 1, 1, 1, 1, 1, 1, 1}, 1'b0);
    expect_out("after_clr", 1, 9, 3);
    for (int i = 0; i < 9; i++) score(1000);
    bus.clear = 1'b1;
    score(1000);
    bus.clear = 1'b0;
    bus.valid_in = 1'b0;
    chk("clr_last_vo", longint'(bus.valid_out), 0);
    chk("clr_last_fc", longint'(bus.frame_count), exp_fc);
    chk("clr_last_dec", longint'(bus.decision), 1);
    step();
    chk("clr_last_pulses", pulses, tot);
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 10; i++)
        rv[i] = f[0] ? int'($urandom_range(7)) - 4 : int'($urandom_range(4095)) - 2048;
      model(rv, e_dec, e_max, e_sec);
      frame(rv, 1'b1);
      expect_out("rand", e_dec, e_max, e_sec);
    end
    bus.valid_in = 1'b0;
    step();
    chk("rand_pulses", pulses, tot);
    for (int i = 0; i < 5; i++) score(i);
    bus.valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_pulses", pulses, tot);
    exp_fc = 0;
    frame('{0, 0, 0, 0, 0, 0, 0, 0, -5, 6}, 1'b0);
    expect_out("post_rst", 9, 6, 0);
    bus.valid_in = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
